boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_pkg.sv | 23 ++
 rtl/boot_loader_if.sv | 18 +
 rtl/boot_loader_inst_mem.sv | 36 +++
 rtl/boot_loader.sv | 203 ++++++++++++++++++++
 tb/tb_boot_loader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader.
//   BYTE_W       : width of one firmware stream byte
//   boot_state_e : loader FSM states, encoded as seen on the state port
//   lane_cnt_w   : width of a byte-lane counter for a given word width
package boot_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } boot_state_e;

  // A one-byte word still needs a 1-bit lane counter to stay a legal vector.
  function automatic int lane_cnt_w(input int data_w);
    int bytes;
    bytes = data_w / BYTE_W;
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Firmware byte-stream handshake.
//   s_valid : source has a byte
//   s_ready : loader accepts a byte
//   s_data  : the byte
//   s_last  : final byte of the image
// master = stream source, slave = boot loader.
interface boot_loader_if;
  import boot_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [BYTE_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/boot_loader_inst_mem.sv
// Instruction memory: simple dual-port, synchronous write, registered read.
//   clk, reset_n : clock and asynchronous active-low reset (read register only)
//   we/waddr/wdata : write port
//   raddr/rdata    : read port, data valid one cycle after raddr
// A read and a write to the same index in one cycle return the old contents.
module inst_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_array [DEPTH];

  // The array itself is never reset so that it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem_array[raddr];
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams a firmware image into instruction memory, releases
// the CPU from reset, and supervises the run until halt or timeout.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : pulse, begins an image load from IDLE or DONE
//   s            : firmware byte stream (slave side)
//   halt         : CPU finished its program
//   pc           : CPU fetch byte address; inst is the word one cycle later
//   cpu_reset_n  : active-low reset to the CPU, high only while running
//   state, word_count, cycle_count : status
//   done, timeout, overflow        : completion flags, held until next start
module boot_loader
  import boot_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  boot_loader_if.slave           s,
  input  logic                   halt,
  input  logic [31:0]            pc,
  output logic [DATA_W-1:0]      inst,
  output logic                   cpu_reset_n,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] word_count,
  output logic [31:0]            cycle_count,
  output logic                   done,
  output logic                   timeout,
  output logic                   overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BYTES  = DATA_W / BYTE_W;
  localparam int OFFS_W = $clog2(BYTES);
  localparam int LANE_W = lane_cnt_w(DATA_W);

  boot_state_e       state_reg;
  logic              s_ready_reg;
  logic              cpu_reset_n_reg;
  logic              done_reg;
  logic              timeout_reg;
  logic              overflow_reg;
  logic              last_seen_reg;
  logic [LANE_W-1:0] lane_reg;
  logic [DATA_W-1:0] word_buf_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [ADDR_W:0]   word_count_reg;
  logic [31:0]       cycle_count_reg;

  logic              accept;
  logic [ADDR_W:0]   fill_count;
  logic              mem_full;
  logic              lane_full;
  logic [DATA_W-1:0] word_merged;
  logic [ADDR_W-1:0] rd_index;

  assign accept    = s.s_valid && s_ready_reg;
  // A completed word waits one cycle before it is written; it already
  // occupies its slot, so it counts toward the fill level.
  assign fill_count = word_count_reg + (ADDR_W+1)'(wr_en_reg);
  assign mem_full   = (fill_count == (ADDR_W+1)'(DEPTH));
  assign lane_full  = (lane_reg == LANE_W'(BYTES - 1));

  // Current word with the incoming byte dropped into its little-endian lane.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign word_merged[gi*BYTE_W +: BYTE_W] =
        (lane_reg == LANE_W'(gi)) ? s.s_data : word_buf_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  // Word index from the byte address; upper bits fall away so fetches wrap.
  assign rd_index = pc[ADDR_W+OFFS_W-1:OFFS_W];

  logic unused_pc_bits;
  generate
    if (OFFS_W > 0) begin : g_pc_offs
      assign unused_pc_bits = ^{pc[31:ADDR_W+OFFS_W], pc[OFFS_W-1:0]};
    end else begin : g_pc_no_offs
      assign unused_pc_bits = ^pc[31:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      s_ready_reg     <= 1'b0;
      cpu_reset_n_reg <= 1'b0;
      done_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      overflow_reg    <= 1'b0;
      last_seen_reg   <= 1'b0;
      lane_reg        <= '0;
      word_buf_reg    <= '0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      word_count_reg  <= '0;
      cycle_count_reg <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      if (wr_en_reg) begin
        word_count_reg <= word_count_reg + (ADDR_W+1)'(1);
      end

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg       <= ST_LOAD;
            s_ready_reg     <= 1'b1;
            cpu_reset_n_reg <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            overflow_reg    <= 1'b0;
            last_seen_reg   <= 1'b0;
            lane_reg        <= '0;
            word_buf_reg    <= '0;
            word_count_reg  <= '0;
            cycle_count_reg <= '0;
          end
        end

        ST_LOAD: begin
          if (accept) begin
            if (mem_full) begin
              // No room: drop the byte and stop with the CPU held in reset.
              overflow_reg <= 1'b1;
              done_reg     <= 1'b1;
              s_ready_reg  <= 1'b0;
              state_reg    <= ST_DONE;
            end else begin
              if (lane_full || s.s_last) begin
                wr_en_reg    <= 1'b1;
                wr_addr_reg  <= fill_count[ADDR_W-1:0];
                wr_data_reg  <= word_merged;
                word_buf_reg <= '0;  // keeps unfilled lanes of the next word at 0
                lane_reg     <= '0;
              end else begin
                word_buf_reg <= word_merged;
                lane_reg     <= lane_reg + LANE_W'(1);
              end
              if (s.s_last) begin
                last_seen_reg <= 1'b1;
                s_ready_reg   <= 1'b0;
              end
            end
          end else if (last_seen_reg && wr_en_reg) begin
            // Final word lands this cycle; the CPU starts on the next one.
            last_seen_reg   <= 1'b0;
            cpu_reset_n_reg <= 1'b1;
            state_reg       <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (halt) begin
            done_reg        <= 1'b1;
            cpu_reset_n_reg <= 1'b0;
            state_reg       <= ST_DONE;
          end else if (cycle_count_reg == 32'(TIMEOUT - 1)) begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
            done_reg        <= 1'b1;
            timeout_reg     <= 1'b1;
            cpu_reset_n_reg <= 1'b0;
            state_reg       <= ST_DONE;
          end else begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  inst_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_inst_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_en_reg),
    .waddr   (wr_addr_reg),
    .wdata   (wr_data_reg),
    .raddr   (rd_index),
    .rdata   (inst)
  );

  assign s.s_ready   = s_ready_reg;
  assign cpu_reset_n = cpu_reset_n_reg;
  assign state       = state_reg;
  assign word_count  = word_count_reg;
  assign cycle_count = cycle_count_reg;
  assign done        = done_reg;
  assign timeout     = timeout_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with DATA_W=32, DEPTH=16, TIMEOUT=50.
module tb_boot_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        cpu_reset_n;
  logic [1:0]  state;
  logic [4:0]  word_count;
  logic [31:0] cycle_count;
  logic        done;
  logic        timeout;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int release_cnt = 0;
  int rel_before;

  logic [7:0] img1 [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] img2 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
  logic [7:0] img4 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

  boot_loader_if s_if ();

  boot_loader #(
    .DATA_W  (32),
    .DEPTH   (16),
    .TIMEOUT (50)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .s           (s_if),
    .halt        (halt),
    .pc          (pc),
    .inst        (inst),
    .cpu_reset_n (cpu_reset_n),
    .state       (state),
    .word_count  (word_count),
    .cycle_count (cycle_count),
    .done        (done),
    .timeout     (timeout),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (cpu_reset_n) release_cnt <= release_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int waited = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = b;
    s_if.s_last  = last;
    while (!s_if.s_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!s_if.s_ready) check_eq("s_ready_wait", 64'(s_if.s_ready), 64'd1);
    tick();
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    pc = '0;
    s_if.s_valid = 1'b0;
    s_if.s_data = '0;
    s_if.s_last = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_s_ready", 64'(s_if.s_ready), 64'd0);
    check_eq("rst_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
    check_eq("rst_inst", 64'(inst), 64'd0);
    check_eq("rst_word_count", 64'(word_count), 64'd0);
    check_eq("rst_cycle_count", 64'(cycle_count), 64'd0);
    check_eq("rst_flags", 64'({done, timeout, overflow}), 64'd0);
    reset_n = 1'b1;
    tick();
    check_eq("idle_state", 64'(state), 64'd0);

    // Image 1: two full words, then timeout
    pulse_start();
    check_eq("t1_load_state", 64'(state), 64'd1);
    check_eq("t1_load_s_ready", 64'(s_if.s_ready), 64'd1);
    for (int i = 0; i < 8; i++) send_byte(img1[i], (i == 7));
    tick();
    check_eq("t1_run_state", 64'(state), 64'd2);
    check_eq("t1_word_count", 64'(word_count), 64'd2);
    check_eq("t1_cpu_reset_n", 64'(cpu_reset_n), 64'd1);
    check_eq("t1_cycle_start", 64'(cycle_count), 64'd0);
    pc = 32'd4;
    tick();
    check_eq("t1_inst_pc4", 64'(inst), 64'h0010_0093);
    pc = 32'd0;
    pulse_start();
    check_eq("t1_inst_pc0", 64'(inst), 64'h0000_0013);
    check_eq("t1_start_ignored", 64'(state), 64'd2);
    for (int i = 0; i < 100 && !done; i++) tick();
    check_eq("t1_done", 64'(done), 64'd1);
    check_eq("t1_timeout", 64'(timeout), 64'd1);
    check_eq("t1_cycle_count", 64'(cycle_count), 64'd50);
    check_eq("t1_cpu_held", 64'(cpu_reset_n), 64'd0);
    check_eq("t1_done_state", 64'(state), 64'd3);

    // Image 2: partial final word, then halt coincident with timeout
    pulse_start();
    check_eq("t2_cleared", 64'({done, timeout, overflow}), 64'd0);
    check_eq("t2_cycle_clr", 64'(cycle_count), 64'd0);
    check_eq("t2_word_clr", 64'(word_count), 64'd0);
    for (int i = 0; i < 6; i++) send_byte(img2[i], (i == 5));
    tick();
    check_eq("t2_word_count", 64'(word_count), 64'd2);
    check_eq("t2_run_state", 64'(state), 64'd2);
    pc = 32'd0;
    tick();
    check_eq("t2_mem0", 64'(inst), 64'hDDCC_BBAA);
    pc = 32'h44;
    tick();
    check_eq("t2_mem1_wrap", 64'(inst), 64'h0000_2211);
    for (int i = 0; i < 100 && cycle_count != 32'd49; i++) tick();
    check_eq("t2_at_49", 64'(cycle_count), 64'd49);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("t2_done", 64'(done), 64'd1);
    check_eq("t2_timeout", 64'(timeout), 64'd0);
    check_eq("t2_cycle_frozen", 64'(cycle_count), 64'd49);
    check_eq("t2_state", 64'(state), 64'd3);

    // Overflow: 65 bytes into a 16-word memory
    rel_before = release_cnt;
    pulse_start();
    for (int i = 0; i < 65; i++) send_byte(8'(i), 1'b0);
    check_eq("ov_overflow", 64'(overflow), 64'd1);
    check_eq("ov_done", 64'(done), 64'd1);
    check_eq("ov_state", 64'(state), 64'd3);
    check_eq("ov_word_count", 64'(word_count), 64'd16);
    check_eq("ov_s_ready", 64'(s_if.s_ready), 64'd0);
    pc = 32'd0;
    tick();
    check_eq("ov_mem0", 64'(inst), 64'h0302_0100);
    pc = 32'd60;
    tick();
    check_eq("ov_mem15", 64'(inst), 64'h3F3E_3D3C);
    check_eq("ov_cpu_never_released", 64'(release_cnt - rel_before), 64'd0);

    // Reset in the middle of a word, then a clean reload
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'(i + 1), 1'b0);
    reset_n = 1'b0;
    #1;
    check_eq("mr_state", 64'(state), 64'd0);
    check_eq("mr_s_ready", 64'(s_if.s_ready), 64'd0);
    check_eq("mr_word_count", 64'(word_count), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(img4[i], (i == 3));
    tick();
    check_eq("mr_run_state", 64'(state), 64'd2);
    check_eq("mr_word_count1", 64'(word_count), 64'd1);
    pc = 32'd0;
    tick();
    check_eq("mr_mem0", 64'(inst), 64'h1122_3344);
    pc = 32'd4;
    tick();
    check_eq("mr_mem1_kept", 64'(inst), 64'h0706_0504);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("mr_halt_done", 64'({state, done}), 64'({2'd3, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
